// File: rtl/unscrambler2_if.sv
// RAM port between the unscrambler and a buffer with synchronous read
// (dout follows r_addr by one cycle) and synchronous write.
interface unscrambler2_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          we;

  modport master (output r_addr, w_addr, din, we, input dout);
  modport slave  (input r_addr, w_addr, din, we, output dout);
endinterface

// File: rtl/unscrambler2.sv
// In-place inverse of the LFSR-driven swap shuffle: regenerates the swap
// partners j_i from the seed, then replays the swaps from the last to the first.
//
// state | meaning
// IDLE  | waiting for start
// GEN   | take r5 from the LFSR
// FOLD  | subtract (len_1+1) until r5 <= len_1
// STORE | record j_i, advance LFSR and i
// RD_I  | read mem[i]
// RD_J  | read mem[j_i], hold mem[i]
// WR_I  | mem[i] <= mem[j_i]
// WR_J  | mem[j_i] <= old mem[i], step i down
// DONE  | one-cycle done pulse
module unscrambler2 #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    seed,
  input  logic [AW-1:0] len_1,
  unscrambler2_if.master ram,
  output logic          busy,
  output logic          done
);

  typedef enum logic [3:0] {
    IDLE, GEN, FOLD, STORE, RD_I, RD_J, WR_I, WR_J, DONE
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [AW-1:0] len_q;
  logic [AW-1:0] i;
  logic [AW-1:0] jreg;
  logic [DW-1:0] temp;
  logic [AW-1:0] jbuf [2**AW];

  logic [AW-1:0] r5;
  logic [AW:0]   len_p1;
  logic [AW:0]   fold_val;
  logic          fold_gt;
  logic [7:0]    lfsr_next;

  assign r5        = lfsr[AW-1:0];
  assign len_p1    = {1'b0, len_q} + (AW+1)'(1);
  // Only used when jreg > len_q, so the difference never wraps.
  assign fold_val  = {1'b0, jreg} - len_p1;
  assign fold_gt   = fold_val > {1'b0, len_q};
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Write data comes straight from the RAM in WR_I so the swap fits in 4 cycles.
  assign ram.din = (state == WR_I) ? ram.dout :
                   (state == WR_J) ? temp     : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= '0;
      len_q      <= '0;
      i          <= '0;
      jreg       <= '0;
      temp       <= '0;
      ram.r_addr <= '0;
      ram.w_addr <= '0;
      ram.we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < 2**AW; k++) jbuf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_1;
            lfsr  <= (seed == 8'h00) ? 8'h01 : seed;
            i     <= '0;
            busy  <= 1'b1;
            if (len_1 == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end
        GEN: begin
          jreg  <= r5;
          state <= (r5 > len_q) ? FOLD : STORE;
        end
        FOLD: begin
          jreg <= fold_val[AW-1:0];
          if (!fold_gt) state <= STORE;
        end
        STORE: begin
          jbuf[i] <= jreg;
          lfsr    <= lfsr_next;
          if (i == len_q - AW'(1)) begin
            ram.r_addr <= i;
            state      <= RD_I;
          end else begin
            i     <= i + AW'(1);
            state <= GEN;
          end
        end
        RD_I: begin
          ram.r_addr <= jbuf[i];
          state      <= RD_J;
        end
        RD_J: begin
          temp       <= ram.dout;
          ram.we     <= 1'b1;
          ram.w_addr <= i;
          state      <= WR_I;
        end
        WR_I: begin
          ram.w_addr <= jbuf[i];
          state      <= WR_J;
        end
        WR_J: begin
          ram.we <= 1'b0;
          if (i == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i          <= i - AW'(1);
            ram.r_addr <= i - AW'(1);
            state      <= RD_I;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unscrambler2.sv
// Bench for unscrambler2: table of hand-derived cases, explicit corner
// sequences and randomized round trips against a forward-shuffle model.
module tb_unscrambler2;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    seed;
  logic [AW-1:0] len_1;
  logic          busy;
  logic          done;

  unscrambler2_if #(.AW(AW), .DW(DW)) bus ();

  unscrambler2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .len_1(len_1),
    .ram(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sync-read RAM with a preload path so only this block writes mem.
  logic [7:0] mem [N];
  logic [7:0] pre [N];
  logic       load_req;
  always @(posedge clk) begin
    if (load_req) for (int k = 0; k < N; k++) mem[k] <= pre[k];
    else if (bus.we) mem[bus.w_addr] <= bus.din;
    bus.dout <= mem[bus.r_addr];
  end

  int busy_cnt = 0;
  int done_cnt = 0;
  int wlog[$];
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (bus.we === 1'b1) wlog.push_back(int'(bus.w_addr) * 256 + int'(bus.din));
  end

  int nchk = 0;
  int nerr = 0;
  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: j_i = (low 5 bits of i-th LFSR value) mod (len+1); returns busy cycles.
  int mj[N];
  function automatic int model_j(input int s, input int len);
    int q, cyc, r5, fb;
    q   = (s == 0) ? 1 : s;
    cyc = 1 + 4 * len;
    for (int k = 0; k < len; k++) begin
      r5    = q % 32;
      mj[k] = r5 % (len + 1);
      cyc  += 2 + r5 / (len + 1);
      fb    = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
      q     = ((q * 2) % 256) | fb;
    end
    return cyc;
  endfunction

  int orig[N];
  int scr[N];

  task automatic preload();
    @(negedge clk);
    for (int k = 0; k < N; k++) pre[k] = 8'(scr[k]);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] s, input int len, input bit hold,
                        output int bc, output int dc, output int w0);
    int b0, d0, cyc;
    @(negedge clk); #1;
    b0 = busy_cnt; d0 = done_cnt; w0 = wlog.size();
    seed = s; len_1 = AW'(len); start = 1'b1;
    @(negedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 2000) begin
      nchk++; nerr++;
      $display("FAIL timeout: busy still high after %0d cycles", cyc);
    end
    bc = busy_cnt - b0;
    dc = done_cnt - d0;
  endtask

  task automatic run_and_check(input logic [7:0] s, input int len, input int exp_busy,
                               input bit hold, input string name);
    int bc, dc, w0, j, t, bad;
    int a[N];
    int exp_w[$];
    for (int k = 0; k < N; k++) orig[k] = int'($urandom_range(0, 255));
    void'(model_j(int'(s), len));
    scr = orig;
    for (int k = 0; k < len; k++) begin
      t = scr[k]; scr[k] = scr[mj[k]]; scr[mj[k]] = t;
    end
    a = scr;
    for (int k = len - 1; k >= 0; k--) begin
      j = mj[k]; t = a[k];
      exp_w.push_back(k * 256 + a[j]);
      exp_w.push_back(j * 256 + t);
      a[k] = a[j]; a[j] = t;
    end
    preload();
    run_op(s, len, hold, bc, dc, w0);
    check({name, " busy_cycles"}, bc, exp_busy);
    check({name, " done_pulses"}, dc, 1);
    check({name, " write_count"}, wlog.size() - w0, exp_w.size());
    for (int k = 0; k < exp_w.size() && w0 + k < wlog.size(); k++)
      check($sformatf("%s write%0d addr*256+data", name, k), wlog[w0 + k], exp_w[k]);
    bad = 0;
    for (int k = 0; k < N; k++) if (int'(mem[k]) != orig[k]) bad++;
    check({name, " restore_mismatches"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] seed;
    int         len;
    int         busy;
  } vec_t;
  vec_t tbl[7];

  int bc, dc, w0, rs, rl;
  int rt_exp[4];
  int rt_addr[6];

  initial begin
    tbl[0] = '{8'h01,  3,  20};
    tbl[1] = '{8'h00,  3,  20};
    tbl[2] = '{8'h01,  0,   1};
    tbl[3] = '{8'h01,  1,   7};
    tbl[4] = '{8'h80,  1,   7};
    tbl[5] = '{8'h01,  2,  13};
    tbl[6] = '{8'hFF,  3,  40};
    rt_exp  = '{10, 20, 30, 40};
    rt_addr = '{2, 0, 1, 2, 0, 1};

    reset = 1'b1; start = 1'b0; seed = '0; len_1 = '0; load_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset r_addr", int'(bus.r_addr), 0);
    check("reset w_addr", int'(bus.w_addr), 0);
    check("reset din",    int'(bus.din),    0);
    check("reset we",     int'(bus.we),     0);
    check("reset busy",   int'(busy),       0);
    check("reset done",   int'(done),       0);
    reset = 1'b0;

    foreach (tbl[v])
      run_and_check(tbl[v].seed, tbl[v].len, tbl[v].busy, 1'b0, $sformatf("tbl%0d", v));

    // Explicit round trip of the 4-element example, seed 0x01 then 0x00.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) scr[k] = 0;
      scr[0] = 10; scr[1] = 30; scr[2] = 20; scr[3] = 40;
      preload();
      run_op((pass == 0) ? 8'h01 : 8'h00, 3, 1'b0, bc, dc, w0);
      check($sformatf("rt%0d busy", pass), bc, 20);
      check($sformatf("rt%0d done", pass), dc, 1);
      for (int k = 0; k < 4; k++)
        check($sformatf("rt%0d mem%0d", pass, k), int'(mem[k]), rt_exp[k]);
      check($sformatf("rt%0d writes", pass), wlog.size() - w0, 6);
      for (int k = 0; k < 6 && w0 + k < wlog.size(); k++)
        check($sformatf("rt%0d swap_addr%0d", pass, k), wlog[w0 + k] / 256, rt_addr[k]);
    end

    // Reset mid-operation: 5 cycles in (sequence phase) and 10 cycles in (WR_I).
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); #1;
      seed = 8'h01; len_1 = AW'(3); start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat ((pass == 0) ? 4 : 9) @(negedge clk);
      #1;
      if (pass == 1) begin
        check("abort WR_I we", int'(bus.we), 1);
        check("abort WR_I w_addr", int'(bus.w_addr), 2);
      end
      reset = 1'b1;
      @(negedge clk);
      check($sformatf("abort%0d we", pass),   int'(bus.we), 0);
      check($sformatf("abort%0d busy", pass), int'(busy),   0);
      check($sformatf("abort%0d done", pass), int'(done),   0);
      #1; reset = 1'b0;
      @(negedge clk);
      check($sformatf("abort%0d idle busy", pass), int'(busy), 0);
    end

    // start held high for the whole operation: exactly one run, one done.
    rs = model_j(8'h37, 5);
    run_and_check(8'h37, 5, rs, 1'b1, "hold");
    dc = done_cnt;
    repeat (4) @(negedge clk);
    check("hold no_restart done", done_cnt - dc, 0);
    check("hold no_restart busy", int'(busy), 0);

    // Full length, then randomized cases.
    run_and_check(8'hA5, 31, 187, 1'b0, "full");
    for (int r = 0; r < 20; r++) begin
      rs = int'($urandom_range(0, 255));
      rl = int'($urandom_range(0, 31));
      run_and_check(8'(rs), rl, model_j(rs, rl), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
